// File: rtl/console_txarb_if.sv
// ---------------------------------------------------------------------------
// console_txarb_if
//   Bundles the two requester character streams, the shared console transmit
//   stream and the arbiter status outputs of console_txarb.
//
//   Requester A   : i_a_stb, i_a_data[6:0] -> arbiter ; o_a_busy <- arbiter
//   Requester B   : i_b_stb, i_b_data[6:0] -> arbiter ; o_b_busy <- arbiter
//   Console       : o_console_stb, o_console_data[6:0] <- arbiter ;
//                   i_console_busy -> arbiter
//   Status        : o_owner[1:0] (00 none, 01 A, 10 B), o_timeout (pulse)
//
//   slave  : the arbiter side
//   master : the environment side (requesters, console sink, observers)
// ---------------------------------------------------------------------------
interface console_txarb_if;
    logic       i_a_stb;
    logic [6:0] i_a_data;
    logic       o_a_busy;

    logic       i_b_stb;
    logic [6:0] i_b_data;
    logic       o_b_busy;

    logic       o_console_stb;
    logic [6:0] o_console_data;
    logic       i_console_busy;

    logic [1:0] o_owner;
    logic       o_timeout;

    modport slave (
        input  i_a_stb, i_a_data, i_b_stb, i_b_data, i_console_busy,
        output o_a_busy, o_b_busy, o_console_stb, o_console_data,
               o_owner, o_timeout
    );

    modport master (
        output i_a_stb, i_a_data, i_b_stb, i_b_data, i_console_busy,
        input  o_a_busy, o_b_busy, o_console_stb, o_console_data,
               o_owner, o_timeout
    );
endinterface

// File: rtl/console_txarb.sv
// ---------------------------------------------------------------------------
// console_txarb
//   Shares one console transmit stream between two character requesters.
//   A requester is granted the console for a whole line: the grant is kept
//   until the owner sends NEWLINE, or until the owner has been idle for
//   2**LGTIMEOUT consecutive cycles, in which case o_timeout pulses.
//   When both request from IDLE, the one that did not own last wins.
//
//   Parameters
//     LGTIMEOUT : log2 of owner-idle cycles before a grant is revoked (2..16)
//     NEWLINE   : character that ends a line and releases the grant
//
//   Ports
//     i_clk     : clock, rising edge
//     i_reset   : synchronous, active-high reset
//     bus       : console_txarb_if.slave (requesters, console, status)
// ---------------------------------------------------------------------------
module console_txarb #(
    parameter int unsigned LGTIMEOUT = 10,
    parameter logic [6:0]  NEWLINE   = 7'h0a
) (
    input logic            i_clk,
    input logic            i_reset,
    console_txarb_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        OWN_A = 2'b01,
        OWN_B = 2'b10
    } state_e;

    // Declaration values match the reset state so simulation and formal
    // start from a known state even before the first reset.
    state_e               state_q      = IDLE;
    state_e               state_d;
    logic                 last_owner_q = 1'b1;   // 0 = A, 1 = B
    logic                 last_owner_d;
    logic [LGTIMEOUT-1:0] idle_cnt_q   = '0;
    logic [LGTIMEOUT-1:0] idle_cnt_d;
    logic                 tx_stb_q     = 1'b0;
    logic                 tx_stb_d;
    logic [6:0]           tx_data_q    = 7'h00;
    logic [6:0]           tx_data_d;
    logic                 timeout_q    = 1'b0;
    logic                 timeout_d;

    logic                 tx_open;
    logic                 owner_stb;
    logic [6:0]           owner_data;
    logic                 accept;

    // The output register can take a new character when it is empty or
    // when the console is consuming the current one this cycle.
    assign tx_open = !tx_stb_q || !bus.i_console_busy;

    // NOTE: every signal written in an always_comb gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        owner_stb  = 1'b0;
        owner_data = 7'h00;
        if (state_q == OWN_A) begin
            owner_stb  = bus.i_a_stb;
            owner_data = bus.i_a_data;
        end else if (state_q == OWN_B) begin
            owner_stb  = bus.i_b_stb;
            owner_data = bus.i_b_data;
        end
    end

    // owner_stb is forced low in IDLE, so nothing is accepted there.
    assign accept = owner_stb && tx_open;

    always_comb begin
        state_d      = state_q;
        last_owner_d = last_owner_q;
        idle_cnt_d   = idle_cnt_q;
        tx_stb_d     = tx_stb_q;
        tx_data_d    = tx_data_q;
        timeout_d    = 1'b0;

        // Output stage: load on accept, empty when drained with nothing new,
        // otherwise hold while the console is busy.
        if (accept) begin
            tx_stb_d  = 1'b1;
            tx_data_d = owner_data;
        end else if (tx_open) begin
            tx_stb_d  = 1'b0;
        end

        case (state_q)
            IDLE: begin
                // Counter is held at zero here so it is clear on grant entry.
                idle_cnt_d = '0;
                if (bus.i_a_stb && !bus.i_b_stb) begin
                    state_d = OWN_A;
                end else if (!bus.i_a_stb && bus.i_b_stb) begin
                    state_d = OWN_B;
                end else if (bus.i_a_stb && bus.i_b_stb) begin
                    state_d = last_owner_q ? OWN_A : OWN_B;
                end
            end

            OWN_A, OWN_B: begin
                if (accept) begin
                    idle_cnt_d = '0;
                    // Release without waiting for the NEWLINE to drain.
                    if (owner_data == NEWLINE) begin
                        state_d      = IDLE;
                        last_owner_d = (state_q == OWN_B);
                    end
                end else if (!owner_stb) begin
                    // Expiry clears the counter, so it never wraps.
                    if (&idle_cnt_q) begin
                        state_d      = IDLE;
                        timeout_d    = 1'b1;
                        last_owner_d = (state_q == OWN_B);
                        idle_cnt_d   = '0;
                    end else begin
                        idle_cnt_d   = idle_cnt_q + 1'b1;
                    end
                end
                // Owner strobing into a busy register: counter holds.
            end

            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its _d value from before the edge, independent of block order.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q      <= IDLE;
            last_owner_q <= 1'b1;
            idle_cnt_q   <= '0;
            tx_stb_q     <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
            idle_cnt_q   <= idle_cnt_d;
            tx_stb_q     <= tx_stb_d;
            timeout_q    <= timeout_d;
        end
        // NOTE: the character register is left out of reset; its contents
        // only matter while tx_stb_q is set, and reset clears that.
        tx_data_q <= tx_data_d;
    end

    assign bus.o_owner        = state_q;
    assign bus.o_a_busy       = (state_q == OWN_A) ? !tx_open : 1'b1;
    assign bus.o_b_busy       = (state_q == OWN_B) ? !tx_open : 1'b1;
    assign bus.o_console_stb  = tx_stb_q;
    assign bus.o_console_data = tx_data_q;
    assign bus.o_timeout      = timeout_q;

endmodule

// File: tb/tb_console_txarb.sv
// ---------------------------------------------------------------------------
// tb_console_txarb
//   Self-checking bench for console_txarb (LGTIMEOUT=3, NEWLINE=7'h0a).
//   Every character a requester hands over is pushed into an expected queue;
//   a separate monitor pops and compares whenever the console takes a
//   character. Directed sequences pin cycle-exact behaviour; a random phase
//   runs two line-oriented requesters against a randomly busy console.
// ---------------------------------------------------------------------------
module tb_console_txarb;

    localparam int         LGT   = 3;
    localparam logic [6:0] NL    = 7'h0a;
    localparam int         BOUND = 300;

    logic clk = 1'b0;
    logic rst;

    console_txarb_if bus ();

    console_txarb #(
        .LGTIMEOUT (LGT),
        .NEWLINE   (NL)
    ) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    int         n_checks   = 0;
    int         n_fail     = 0;
    logic [6:0] exp_q[$];
    logic [6:0] exp_d;
    int         line_src   = 0;   // line in progress: 0 none, 1 A, 2 B
    bit         rand_phase = 1'b0;
    bit         drv_done   = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic expect_outs(input string tag, input int owner, input int cstb,
                               input int abusy, input int bbusy, input int tmo);
        check({tag, ".owner"},   int'(bus.o_owner),       owner);
        check({tag, ".con_stb"}, int'(bus.o_console_stb), cstb);
        check({tag, ".a_busy"},  int'(bus.o_a_busy),      abusy);
        check({tag, ".b_busy"},  int'(bus.o_b_busy),      bbusy);
        check({tag, ".timeout"}, int'(bus.o_timeout),     tmo);
    endtask

    task automatic expect_data(input string tag, input int d);
        check({tag, ".con_data"}, int'(bus.o_console_data), d);
    endtask

    task automatic do_reset();
        rst                = 1'b1;
        bus.i_a_stb        = 1'b0;
        bus.i_b_stb        = 1'b0;
        bus.i_a_data       = 7'h00;
        bus.i_b_data       = 7'h00;
        bus.i_console_busy = 1'b0;
        tick();
        at_neg();
        expect_outs("reset", 0, 0, 1, 1, 0);
        tick();
        rst = 1'b0;
    endtask

    task automatic drain(input string tag);
        repeat (4) tick();
        at_neg();
        check({tag, ".drained"}, exp_q.size(), 0);
        tick();
    endtask

    // Stimulus side: record each character handed over and check lines
    // from the two requesters are never interleaved.
    task automatic note_accept(input int src, input logic [6:0] ch);
        exp_q.push_back(ch);
        check("line_not_interleaved", int'(line_src == 0 || line_src == src), 1);
        line_src = (ch == NL) ? 0 : src;
    endtask

    always @(negedge clk) begin : accept_tracker
        if (!rst) begin
            if (bus.i_a_stb && !bus.o_a_busy) note_accept(1, bus.i_a_data);
            if (bus.i_b_stb && !bus.o_b_busy) note_accept(2, bus.i_b_data);
            if (rand_phase) begin
                check("rand.no_timeout", int'(bus.o_timeout), 0);
                if (bus.o_owner != 2'b01) check("rand.a_busy_nonowner", int'(bus.o_a_busy), 1);
                if (bus.o_owner != 2'b10) check("rand.b_busy_nonowner", int'(bus.o_b_busy), 1);
            end
        end
    end

    // Console side: every character taken by the console must be the next
    // one handed over; a reset discards whatever was pending.
    always @(negedge clk) begin : console_monitor
        if (rst) begin
            exp_q.delete();
            line_src = 0;
        end else if (bus.o_console_stb && !bus.i_console_busy) begin
            check("console_char_expected", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                exp_d = exp_q.pop_front();
                check("console_char", int'(bus.o_console_data), int'(exp_d));
            end
        end
    end

    task automatic set_req(input int src, input logic stb, input logic [6:0] d);
        if (src == 1) begin
            bus.i_a_stb  = stb;
            bus.i_a_data = d;
        end else begin
            bus.i_b_stb  = stb;
            bus.i_b_data = d;
        end
    endtask

    function automatic logic req_busy(input int src);
        return (src == 1) ? bus.o_a_busy : bus.o_b_busy;
    endfunction

    // Line-oriented requester: random printable-ish characters, each line
    // ended by NEWLINE, short gaps that stay well under the timeout.
    task automatic drive_lines(input int src, input int n_lines);
        int         len;
        int         gap;
        int         waited;
        logic [6:0] ch;
        for (int l = 0; l < n_lines; l++) begin
            len = int'($urandom_range(1, 4));
            for (int c = 0; c <= len; c++) begin
                gap = int'($urandom_range(0, 5));
                if (gap > 0) begin
                    set_req(src, 1'b0, 7'h00);
                    repeat (gap) tick();
                end
                ch = 7'($urandom_range(0, 127));
                if (ch == NL) ch = 7'h20;
                if (c == len) ch = NL;
                set_req(src, 1'b1, ch);
                waited = 0;
                at_neg();
                while (req_busy(src) && waited < BOUND) begin
                    waited++;
                    at_neg();
                end
                check("req_wait_within_bound", int'(waited < BOUND), 1);
                tick();
            end
            set_req(src, 1'b0, 7'h00);
        end
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation still running at t=%0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        // ---- reset state, then "hi\n" from A with an idle console ----
        do_reset();
        bus.i_a_stb = 1'b1; bus.i_a_data = 7'h68;
        at_neg(); expect_outs("hi_c0", 0, 0, 1, 1, 0);
        tick();   at_neg(); expect_outs("hi_c1", 1, 0, 0, 1, 0);
        tick();   bus.i_a_data = 7'h69;
        at_neg(); expect_outs("hi_c2", 1, 1, 0, 1, 0); expect_data("hi_c2", 'h68);
        tick();   bus.i_a_data = NL;
        at_neg(); expect_outs("hi_c3", 1, 1, 0, 1, 0); expect_data("hi_c3", 'h69);
        tick();   bus.i_a_stb = 1'b0;
        at_neg(); expect_outs("hi_c4", 0, 1, 1, 1, 0); expect_data("hi_c4", 'h0a);
        tick();   at_neg(); expect_outs("hi_c5", 0, 0, 1, 1, 0);
        drain("hi");

        // ---- tie after reset: A first, released A loses to waiting B ----
        do_reset();
        bus.i_a_stb = 1'b1; bus.i_a_data = 7'h31;
        bus.i_b_stb = 1'b1; bus.i_b_data = 7'h32;
        at_neg(); expect_outs("tie_c0", 0, 0, 1, 1, 0);
        tick();   at_neg(); expect_outs("tie_c1", 1, 0, 0, 1, 0);
        tick();   bus.i_a_data = NL;
        at_neg(); expect_outs("tie_c2", 1, 1, 0, 1, 0); expect_data("tie_c2", 'h31);
        tick();   bus.i_a_data = 7'h33;
        at_neg(); expect_outs("tie_c3", 0, 1, 1, 1, 0);
        tick();   at_neg(); expect_outs("tie_c4", 2, 0, 1, 0, 0);
        tick();   bus.i_b_data = NL;
        at_neg(); expect_outs("tie_c5", 2, 1, 1, 0, 0); expect_data("tie_c5", 'h32);
        tick();   bus.i_b_stb = 1'b0;
        at_neg(); expect_outs("tie_c6", 0, 1, 1, 1, 0);
        tick();   at_neg(); expect_outs("tie_c7", 1, 0, 0, 1, 0);
        tick();   bus.i_a_data = NL;
        at_neg(); expect_outs("tie_c8", 1, 1, 0, 1, 0); expect_data("tie_c8", 'h33);
        tick();   bus.i_a_stb = 1'b0;
        at_neg(); expect_outs("tie_c9", 0, 1, 1, 1, 0);
        // A alone again after owning last: granted
        tick();   bus.i_a_stb = 1'b1; bus.i_a_data = 7'h34;
        at_neg(); expect_outs("alone_c0", 0, 0, 1, 1, 0);
        tick();   at_neg(); expect_outs("alone_c1", 1, 0, 0, 1, 0);
        tick();   bus.i_a_data = NL;
        tick();   bus.i_a_stb = 1'b0;
        at_neg(); check("alone_c3.owner", int'(bus.o_owner), 0);
        drain("tie");

        // ---- console stall: output and busy hold for 5 cycles ----
        bus.i_a_stb = 1'b1; bus.i_a_data = 7'h55;
        at_neg(); expect_outs("stall_c0", 0, 0, 1, 1, 0);
        tick();   at_neg(); expect_outs("stall_c1", 1, 0, 0, 1, 0);
        tick();   bus.i_console_busy = 1'b1; bus.i_a_data = 7'h56;
        for (int i = 0; i < 5; i++) begin
            at_neg(); expect_outs("stall_hold", 1, 1, 1, 1, 0); expect_data("stall_hold", 'h55);
            tick();
        end
        bus.i_console_busy = 1'b0;
        at_neg(); expect_outs("stall_rel", 1, 1, 0, 1, 0); expect_data("stall_rel", 'h55);
        tick();   bus.i_a_data = NL;
        at_neg(); expect_data("stall_next", 'h56);
        tick();   bus.i_a_stb = 1'b0;
        at_neg(); check("stall_end.owner", int'(bus.o_owner), 0);
        drain("stall");

        // ---- timeout: request at expiry saves the grant, then 8 idle ----
        do_reset();
        bus.i_a_stb = 1'b1; bus.i_a_data = 7'h41;
        bus.i_b_stb = 1'b1; bus.i_b_data = 7'h42;
        at_neg(); expect_outs("to_c0", 0, 0, 1, 1, 0);
        tick();   at_neg(); expect_outs("to_c1", 1, 0, 0, 1, 0);
        tick();   bus.i_a_stb = 1'b0;
        for (int i = 0; i < 7; i++) begin
            at_neg();
            check("to_idle1.owner", int'(bus.o_owner), 1);
            check("to_idle1.timeout", int'(bus.o_timeout), 0);
            tick();
        end
        bus.i_a_stb = 1'b1; bus.i_a_data = 7'h43;
        at_neg();
        check("to_save.owner", int'(bus.o_owner), 1);
        check("to_save.timeout", int'(bus.o_timeout), 0);
        tick();   bus.i_a_stb = 1'b0;
        for (int i = 0; i < 8; i++) begin
            at_neg();
            check("to_idle2.owner", int'(bus.o_owner), 1);
            check("to_idle2.timeout", int'(bus.o_timeout), 0);
            tick();
        end
        at_neg(); expect_outs("to_pulse", 0, 0, 1, 1, 1);
        line_src = 0;   // A's line was cut short by the revoke
        tick();   at_neg(); expect_outs("to_b_grant", 2, 0, 1, 0, 0);
        tick();   bus.i_b_data = NL;
        tick();   bus.i_b_stb = 1'b0;
        at_neg(); check("to_end.owner", int'(bus.o_owner), 0);
        drain("to");

        // ---- reset while a character is held by a busy console ----
        do_reset();
        bus.i_a_stb = 1'b1; bus.i_a_data = 7'h33;
        tick();
        tick();   bus.i_console_busy = 1'b1; bus.i_a_stb = 1'b0;
        at_neg(); expect_outs("rst_held", 1, 1, 1, 1, 0); expect_data("rst_held", 'h33);
        tick();   rst = 1'b1;
        tick();   rst = 1'b0;
        at_neg(); expect_outs("rst_mid", 0, 0, 1, 1, 0);
        bus.i_console_busy = 1'b0;
        drain("rst");

        // ---- random lines from both requesters, randomly busy console ----
        rand_phase = 1'b1;
        fork
            begin
                fork
                    drive_lines(1, 6);
                    drive_lines(2, 6);
                join
                drv_done = 1'b1;
            end
            begin
                while (!drv_done) begin
                    tick();
                    bus.i_console_busy = ($urandom_range(0, 2) == 0);
                end
            end
        join
        bus.i_console_busy = 1'b0;
        drain("rand");
        rand_phase = 1'b0;
        check("rand.line_closed", line_src, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
